// File: rtl/lif_pkg.sv
// Shared seven-segment definitions for the LIF neuron display path.
// Segment bit order is a=bit0 through g=bit6, active-high.
package lif_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/lif_spike_display_seg7_hex.sv
// Hex digit to seven-segment decoder, purely combinational table lookup.
// Zero latency; no flow control.
module seg7_hex
    import lif_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/lif_spike_display.sv
// Windowed spike counter with hex display and spike LED stretcher.
// All outputs registered (1-cycle latency); no backpressure, accepts a spike every cycle.
module lif_spike_display
    import lif_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 10_000_000,
    parameter int STRETCH_CYCLES = 1_000_000,
    parameter int COUNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike,
    input  logic [7:0]       membrane,
    input  logic             mode,
    output logic [SEG_W-1:0] segments,
    output logic             spike_led,
    output logic             window_done
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [STR_W-1:0]   STR_LOAD = STR_W'(STRETCH_CYCLES);
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    logic [WIN_W-1:0]   win_cnt_q,     win_cnt_d;
    logic [COUNT_W-1:0] spike_cnt_q,   spike_cnt_d;
    logic [COUNT_W-1:0] latched_cnt_q, latched_cnt_d;
    logic [STR_W-1:0]   stretch_cnt_q, stretch_cnt_d;
    logic [SEG_W-1:0]   segments_q,    segments_d;
    logic               spike_led_q,   spike_led_d;
    logic               window_done_q, window_done_d;

    logic               win_end;
    logic [COUNT_W-1:0] cnt_inc;
    logic [3:0]         disp_src;

    // Saturating increment also folds in a spike landing on the closing cycle.
    assign win_end  = (win_cnt_q == WIN_LAST);
    assign cnt_inc  = (spike && (spike_cnt_q != CNT_MAX)) ? spike_cnt_q + 1'b1 : spike_cnt_q;
    assign disp_src = mode ? membrane[7:4] : 4'(latched_cnt_q);

    seg7_hex u_seg7_hex (
        .hex_i (disp_src),
        .seg_o (segments_d)
    );

    always_comb begin
        win_cnt_d     = win_cnt_q + 1'b1;
        spike_cnt_d   = cnt_inc;
        latched_cnt_d = latched_cnt_q;
        window_done_d = 1'b0;
        if (win_end) begin
            win_cnt_d     = '0;
            spike_cnt_d   = '0;
            latched_cnt_d = cnt_inc;
            window_done_d = 1'b1;
        end
    end

    always_comb begin
        stretch_cnt_d = (stretch_cnt_q != '0) ? stretch_cnt_q - 1'b1 : '0;
        spike_led_d   = (stretch_cnt_q > STR_W'(1));
        if (spike) begin
            stretch_cnt_d = STR_LOAD;
            spike_led_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q     <= '0;
            spike_cnt_q   <= '0;
            latched_cnt_q <= '0;
            stretch_cnt_q <= '0;
            segments_q    <= '0;
            spike_led_q   <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            spike_cnt_q   <= spike_cnt_d;
            latched_cnt_q <= latched_cnt_d;
            stretch_cnt_q <= stretch_cnt_d;
            segments_q    <= segments_d;
            spike_led_q   <= spike_led_d;
            window_done_q <= window_done_d;
        end
    end

    assign segments    = segments_q;
    assign spike_led   = spike_led_q;
    assign window_done = window_done_q;

endmodule

// File: tb/tb_lif_spike_display.sv
// Directed bench for lif_spike_display with a 16-cycle window and 4-cycle LED stretch.
module tb_lif_spike_display;

    logic       clk;
    logic       rst_n;
    logic       spike;
    logic [7:0] membrane;
    logic       mode;
    logic [6:0] segments;
    logic       spike_led;
    logic       window_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int e      = 0;

    lif_spike_display #(
        .WINDOW_CYCLES  (16),
        .STRETCH_CYCLES (4),
        .COUNT_W        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike       (spike),
        .membrane    (membrane),
        .mode        (mode),
        .segments    (segments),
        .spike_led   (spike_led),
        .window_done (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count e is the number of rising edges since the latest reset release.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        e += n;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %02h expected %02h", tag, e, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        spike    = 1'b0;
        membrane = 8'h00;
        mode     = 1'b0;

        step(3);
        chk("rst_seg", {1'b0, segments}, 8'h00);
        chk("rst_led", {7'b0, spike_led}, 8'h00);
        chk("rst_wd",  {7'b0, window_done}, 8'h00);

        rst_n = 1'b1;
        e = 0;
        step(1);
        chk("first_seg", {1'b0, segments}, 8'h3F);

        // Three single spikes sampled at edges 3, 6, 9.
        step(1); spike = 1'b1; step(1); spike = 1'b0;
        step(2); spike = 1'b1; step(1); spike = 1'b0;
        step(2); spike = 1'b1; step(1); spike = 1'b0;
        step(6);
        chk("w1_wd_early", {7'b0, window_done}, 8'h00);
        step(1);
        chk("w1_wd", {7'b0, window_done}, 8'h01);
        step(1);
        chk("w1_wd_clear", {7'b0, window_done}, 8'h00);
        chk("w1_seg3", {1'b0, segments}, 8'h4F);

        // Window 2 idle: digit holds until the next latch.
        step(15);
        chk("w2_hold", {1'b0, segments}, 8'h4F);
        chk("w2_wd", {7'b0, window_done}, 8'h01);
        spike = 1'b1;
        step(1);
        chk("w2_seg0", {1'b0, segments}, 8'h3F);

        // Window 3: spike high all 16 cycles saturates at F.
        step(15);
        spike = 1'b0;
        chk("w3_wd", {7'b0, window_done}, 8'h01);
        step(1);
        chk("w3_sat", {1'b0, segments}, 8'h71);

        // Window 4: single spike only on the closing cycle.
        step(14);
        spike = 1'b1;
        step(1);
        spike = 1'b0;
        chk("w4_wd", {7'b0, window_done}, 8'h01);
        step(1);
        chk("w4_last", {1'b0, segments}, 8'h06);

        // Window 5: membrane display mode.
        mode = 1'b1; membrane = 8'h9C;
        step(1);
        chk("mem_9c", {1'b0, segments}, 8'h6F);
        membrane = 8'hA0;
        step(1);
        chk("mem_a0", {1'b0, segments}, 8'h77);
        mode = 1'b0;
        step(1);
        chk("mode_back", {1'b0, segments}, 8'h06);
        step(11);
        chk("w5_wd_early", {7'b0, window_done}, 8'h00);
        step(1);
        chk("w5_wd", {7'b0, window_done}, 8'h01);

        // Window 6: stretcher, single pulse then retrigger.
        step(1); spike = 1'b1;
        step(1); spike = 1'b0;
        chk("led_s0", {7'b0, spike_led}, 8'h01);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("led_single", {7'b0, spike_led}, 8'h01);
        end
        step(1);
        chk("led_off", {7'b0, spike_led}, 8'h00);
        step(2); spike = 1'b1;
        step(1); spike = 1'b0;
        chk("led_r0", {7'b0, spike_led}, 8'h01);
        step(1);
        chk("led_r1", {7'b0, spike_led}, 8'h01);
        spike = 1'b1;
        step(1); spike = 1'b0;
        chk("led_r2", {7'b0, spike_led}, 8'h01);
        for (int i = 3; i < 6; i++) begin
            step(1);
            chk("led_ext", {7'b0, spike_led}, 8'h01);
        end
        step(1);
        chk("led_r_off", {7'b0, spike_led}, 8'h00);
        step(1);
        chk("w6_wd", {7'b0, window_done}, 8'h01);
        step(1);
        chk("w6_seg3", {1'b0, segments}, 8'h4F);

        // Window 7: five spikes, then reset mid-window.
        spike = 1'b1;
        step(5);
        spike = 1'b0;
        step(2);
        chk("pre_rst_seg", {1'b0, segments}, 8'h4F);
        chk("pre_rst_led", {7'b0, spike_led}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", {1'b0, segments}, 8'h00);
        chk("mid_rst_led", {7'b0, spike_led}, 8'h00);
        chk("mid_rst_wd",  {7'b0, window_done}, 8'h00);
        step(2);
        rst_n = 1'b1;
        e = 0;
        step(1);
        chk("rel_seg", {1'b0, segments}, 8'h3F);
        step(14);
        chk("rel_wd_early", {7'b0, window_done}, 8'h00);
        step(1);
        chk("rel_wd", {7'b0, window_done}, 8'h01);
        step(1);
        chk("rel_discard", {1'b0, segments}, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
